mouse_packet_decoder: RTL

//   Consumes the byte stream from the PS/2 mouse byte receiver. Assembles standard 3-byte

---
 rtl/mouse_packet_decoder.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mouse_packet_decoder.sv
// PS/2 mouse packet decoder: assembles 3-byte movement packets and keeps a
// clamped cursor position plus button state for the color mapper.
module mouse_packet_decoder #(
    parameter int X_MAX       = 639,
    parameter int Y_MAX       = 479,
    parameter int X_INIT      = 320,
    parameter int Y_INIT      = 240,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic [9:0] BallX,
    output logic [9:0] BallY,
    output logic [7:0] MouseButtons,
    output logic       packet_valid,
    output logic       sync_err
);

    typedef enum logic [1:0] {WAIT_B0, WAIT_B1, WAIT_B2, UPDATE} state_t;

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0]     TO_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic signed [10:0] XMAX_S = 11'(X_MAX);
    localparam logic signed [10:0] YMAX_S = 11'(Y_MAX);

    state_t        state, state_nxt;
    logic [7:0]    b0, b1, b2;
    logic [CW-1:0] cnt;
    logic          ld_b0, ld_b1, ld_b2, err_nxt, to_hit, do_upd;
    logic signed [10:0] dx, dy, nx, ny;
    logic [9:0]    nx_c, ny_c;

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= WAIT_B0;
        else       state <= state_nxt;
    end

    // Next-state logic; a byte arriving in UPDATE is handled as a header
    // so that back-to-back packets never lose a byte.
    always_comb begin
        state_nxt = state;
        ld_b0     = 1'b0;
        ld_b1     = 1'b0;
        ld_b2     = 1'b0;
        err_nxt   = 1'b0;
        to_hit    = 1'b0;
        do_upd    = 1'b0;
        case (state)
            WAIT_B0, UPDATE: begin
                do_upd    = (state == UPDATE);
                state_nxt = WAIT_B0;
                if (byte_valid) begin
                    if (byte_in[3]) begin
                        ld_b0     = 1'b1;
                        state_nxt = WAIT_B1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            WAIT_B1: begin
                if (byte_valid) begin
                    ld_b1     = 1'b1;
                    state_nxt = WAIT_B2;
                end else if (cnt == TO_LAST) begin
                    to_hit    = 1'b1;
                    err_nxt   = 1'b1;
                    state_nxt = WAIT_B0;
                end
            end
            WAIT_B2: begin
                if (byte_valid) begin
                    ld_b2     = 1'b1;
                    state_nxt = UPDATE;
                end else if (cnt == TO_LAST) begin
                    to_hit    = 1'b1;
                    err_nxt   = 1'b1;
                    state_nxt = WAIT_B0;
                end
            end
            default: state_nxt = WAIT_B0;
        endcase
    end

    // Idle counter: only runs between bytes of a packet, any byte clears it
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            cnt <= '0;
        else if ((state == WAIT_B1 || state == WAIT_B2) && !byte_valid && !to_hit)
            cnt <= cnt + CW'(1);
        else
            cnt <= '0;
    end

    // Packet byte capture
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            b0 <= '0;
            b1 <= '0;
            b2 <= '0;
        end else begin
            if (ld_b0) b0 <= byte_in;
            if (ld_b1) b1 <= byte_in;
            if (ld_b2) b2 <= byte_in;
        end
    end

    // New position: 9-bit deltas widened to 11 bits, overflowed axes ignored,
    // Y inverted so mouse-up moves toward row 0, then clamped to the screen.
    always_comb begin
        dx = b0[6] ? 11'sd0 : $signed({{3{b0[4]}}, b1});
        dy = b0[7] ? 11'sd0 : $signed({{3{b0[5]}}, b2});
        nx = $signed({1'b0, BallX}) + dx;
        ny = $signed({1'b0, BallY}) - dy;
        if (nx[10])           nx_c = '0;
        else if (nx > XMAX_S) nx_c = XMAX_S[9:0];
        else                  nx_c = nx[9:0];
        if (ny[10])           ny_c = '0;
        else if (ny > YMAX_S) ny_c = YMAX_S[9:0];
        else                  ny_c = ny[9:0];
    end

    // Registered outputs and status pulses
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            BallX        <= 10'(X_INIT);
            BallY        <= 10'(Y_INIT);
            MouseButtons <= '0;
            packet_valid <= 1'b0;
            sync_err     <= 1'b0;
        end else begin
            packet_valid <= do_upd;
            sync_err     <= err_nxt;
            if (do_upd) begin
                BallX        <= nx_c;
                BallY        <= ny_c;
                MouseButtons <= {5'b0, b0[2:0]};
            end
        end
    end

endmodule
